// File: rtl/fdce_arb_pkg.sv
// fdce_arb_pkg: shared types and helpers for the FDCE round-robin write arbiter
package fdce_arb_pkg;

    typedef enum logic {EMPTY, FULL} arb_state_t;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin pick (rotate, priority-encode, un-rotate)
module rr_priority_pick
    import fdce_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = id_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt,
    output logic         any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   idx;
    logic [W:0]     sum;

    // rot[k] is req[(ptr+k) mod N], so the lowest set bit is the next in turn
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) idx = W'(i);
        sum = {1'b0, idx} + {1'b0, ptr};
        gnt = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
    end

    assign any = |req;

endmodule

// File: rtl/fdce_rr_write_arbiter.sv
// fdce_rr_write_arbiter: round-robin arbiter loading one CE-gated, async-clear holding register
module fdce_rr_write_arbiter
    import fdce_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic                    C,
    input  logic                    CLR,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [ID_W-1:0]         out_id,
    input  logic                    out_ready
);

    arb_state_t      state, state_nxt;
    logic [ID_W-1:0] ptr, gnt;
    logic            any, ce;

    rr_priority_pick #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    // CLR gates ce so no handshake can complete while reset is held
    assign ce        = !CLR && any && (state == EMPTY || out_ready);
    assign req_ready = ce ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt) : '0;
    assign out_valid = state == FULL;

    always_comb state_nxt = ce ? FULL : (out_ready ? EMPTY : state);

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            state <= state_nxt;
            if (ce) begin
                out_data <= req_data[gnt*DATA_W +: DATA_W];
                out_id   <= gnt;
                ptr      <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fdce_rr_write_arbiter.sv
// tb_fdce_rr_write_arbiter: directed scenarios plus randomized traffic against a reference model
module tb_fdce_rr_write_arbiter;

    localparam int N = 4;

    logic        C = 1'b0;
    logic        CLR = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bit         m_valid = 0;
    logic [7:0] m_data = '0;
    int         m_id = 0;
    int         m_ptr = 0;

    fdce_rr_write_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .C         (C),
        .CLR       (CLR),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 C = ~C;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r = '0;
        if (!CLR && (!m_valid || out_ready) && |req_valid) r[pick(req_valid, m_ptr)] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] lane(input int i);
        return req_data[i*8 +: 8];
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    // advance one clock, update the reference model from the inputs seen at the edge
    task automatic tick();
        int g;
        @(posedge C);
        if (!CLR && |req_valid && (!m_valid || out_ready)) begin
            g       = pick(req_valid, m_ptr);
            m_data  = lane(g);
            m_id    = g;
            m_ptr   = (g + 1) % N;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'hf;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data); end
        vectors++; if (out_id !== 2'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", out_id); end
        @(negedge C);
        CLR = 1'b0;
        model_reset();
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_first_ready got %b want 0001", req_ready); end
        req_valid = 4'b0100;
        req_data  = 32'h005C_0000;
        out_ready = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h5C || out_id !== 2'd2) begin
            miscompares++; $display("FAIL reset_load got v=%b d=%h id=%0d want v=1 d=5c id=2", out_valid, out_data, out_id);
        end
        req_valid = 4'hf;
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        vectors++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
            miscompares++; $display("FAIL reset_async got v=%b d=%h id=%0d want v=0 d=00 id=0", out_valid, out_data, out_id);
        end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_async_ready got %b want 0000", req_ready); end
        @(negedge C);
        CLR = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_ptr got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        req_valid = 4'hf;
        req_data  = 32'hD3C2_B1A0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++; if (req_ready !== 4'(1 << order[k])) begin
                miscompares++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << order[k]));
            end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_id !== 2'(order[k]) || out_data !== lane(order[k])) begin
                miscompares++; $display("FAIL rr_out[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                                        k, out_valid, out_id, out_data, order[k], lane(order[k]));
            end
        end
    endtask

    task automatic test_wrap();
        req_valid = 4'b0000;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1001;
        req_data  = 32'h3300_0030;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL wrap_first got %b want 1000", req_ready); end
        tick();
        vectors++; if (out_id !== 2'd3 || out_data !== 8'h33) begin miscompares++; $display("FAIL wrap_id3 got id=%0d d=%h want id=3 d=33", out_id, out_data); end
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL wrap_second got %b want 0001", req_ready); end
        tick();
        vectors++; if (out_id !== 2'd0 || out_data !== 8'h30) begin miscompares++; $display("FAIL wrap_id0 got id=%0d d=%h want id=0 d=30", out_id, out_data); end
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL wrap_ptr1 got %b want 1000", req_ready); end
    endtask

    task automatic test_stall();
        logic [7:0] held;
        out_ready = 1'b0;
        req_valid = 4'b0110;
        req_data  = 32'h006B_5A00;
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_data !== held) begin
                miscompares++; $display("FAIL stall_hold[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, held);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL stall_release got %b want 0010", req_ready); end
        tick();
        vectors++; if (out_id !== 2'd1 || out_data !== 8'h5A) begin miscompares++; $display("FAIL stall_after got id=%0d d=%h want id=1 d=5a", out_id, out_data); end
    endtask

    task automatic test_drain();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_id !== 2'd2) begin
            miscompares++; $display("FAIL drain_load got v=%b d=%h id=%0d want v=1 d=a5 id=2", out_valid, out_data, out_id);
        end
        req_valid = 4'b0000;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL drain_ready got %b want 0000", req_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_id !== 2'd2) begin
            miscompares++; $display("FAIL drain_empty got v=%b d=%h id=%0d want v=0 d=a5 id=2", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_same_edge();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0011;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_id !== 2'd0) begin
            miscompares++; $display("FAIL same_first got v=%b d=%h id=%0d want v=1 d=11 id=0", out_valid, out_data, out_id);
        end
        req_valid = 4'b0100;
        req_data  = 32'h0022_0000;
        out_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL same_ready got %b want 0100", req_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_id !== 2'd2) begin
            miscompares++; $display("FAIL same_swap got v=%b d=%h id=%0d want v=1 d=22 id=2", out_valid, out_data, out_id);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] acc = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++; if (req_ready !== exp_ready()) begin
                miscompares++; $display("FAIL rand_ready[%0d] got %b want %b", k, req_ready, exp_ready());
            end
            acc = req_ready;
            tick();
            vectors++; if (out_valid !== m_valid || out_data !== m_data || out_id !== 2'(m_id)) begin
                miscompares++; $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d want v=%b d=%h id=%0d",
                                        k, out_valid, out_data, out_id, m_valid, m_data, m_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_drain();
        test_same_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
